// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the parametrised accumulator CPU core.
//   - opcode constants (IR[7:4])
//   - FSM state encoding, exported on the 5-bit debug 'state' port
//   - helpers that slice the instruction register into opcode / RD / RS
package cpu_pkg;

   localparam int unsigned IrW = 8;

   localparam logic [3:0] OpNop = 4'h0;
   localparam logic [3:0] OpAdd = 4'h1;
   localparam logic [3:0] OpSub = 4'h2;
   localparam logic [3:0] OpNot = 4'h3;
   localparam logic [3:0] OpAnd = 4'h4;
   localparam logic [3:0] OpOr  = 4'h5;
   localparam logic [3:0] OpMov = 4'h6;
   localparam logic [3:0] OpSt  = 4'h7;
   localparam logic [3:0] OpLdi = 4'h8;
   localparam logic [3:0] OpLd  = 4'h9;
   localparam logic [3:0] OpJmp = 4'hA;
   localparam logic [3:0] OpJnz = 4'hB;
   localparam logic [3:0] OpMul = 4'hC;

   typedef enum logic [4:0] {
      StRst  = 5'd0,
      StF0   = 5'd1,
      StF1   = 5'd2,
      StF2   = 5'd3,
      StEx   = 5'd4,
      StOpw  = 5'd5,
      StOpl  = 5'd6,
      StStw  = 5'd7,
      StSte  = 5'd8,
      StLda  = 5'd9,
      StLdw1 = 5'd10,
      StLdw2 = 5'd11,
      StLdl  = 5'd12
   } state_e;

   function automatic logic [3:0] ir_opcode(input logic [IrW-1:0] ir);
      return ir[7:4];
   endfunction

   function automatic logic [1:0] ir_rd(input logic [IrW-1:0] ir);
      return ir[3:2];
   endfunction

   function automatic logic [1:0] ir_rs(input logic [IrW-1:0] ir);
      return ir[1:0];
   endfunction

   // ST, LDI, LD, JMP and JNZ carry an operand word in the following ROM location.
   function automatic logic has_operand(input logic [3:0] op);
      return (op >= OpSt) && (op <= OpJnz);
   endfunction

endpackage

// File: rtl/cpu_core_param_if.sv
// cpu_core_param_if: program/data memory bus of the CPU core.
//   rom_address  core -> mem  registered program-memory address
//   rom_data     mem -> core  program-memory read data (1-cycle sync read)
//   ram_address  core -> mem  registered data-memory address
//   ram_data_in  core -> mem  data-memory write data
//   ram_data_out mem -> core  data-memory read data (1-cycle sync read)
//   ram_write    core -> mem  data-memory write enable, one-cycle pulse
// Modports: master = CPU core, slave = memory / board wrapper.
interface cpu_core_param_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
);

   logic [ADDR_W-1:0] rom_address;
   logic [DATA_W-1:0] rom_data;
   logic [ADDR_W-1:0] ram_address;
   logic [DATA_W-1:0] ram_data_in;
   logic [DATA_W-1:0] ram_data_out;
   logic              ram_write;

   modport master (
      output rom_address,
      input  rom_data,
      output ram_address,
      output ram_data_in,
      input  ram_data_out,
      output ram_write
   );

   modport slave (
      input  rom_address,
      output rom_data,
      input  ram_address,
      input  ram_data_in,
      output ram_data_out,
      input  ram_write
   );

endinterface

// File: rtl/cpu_alu.sv
// cpu_alu: combinational datapath of the CPU core.
//   op_i       opcode (IR[7:4])
//   a_i        RD operand
//   b_i        RS operand
//   result_o   DATA_W result for ADD/SUB/NOT/AND/OR/MOV (a_i otherwise)
//   product_o  unsigned 2*DATA_W product a_i * b_i for MUL
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic [3:0]          op_i,
   input  logic [DATA_W-1:0]   a_i,
   input  logic [DATA_W-1:0]   b_i,
   output logic [DATA_W-1:0]   result_o,
   output logic [2*DATA_W-1:0] product_o
);

   always_comb begin
      result_o = a_i;
      case (op_i)
         OpAdd:   result_o = a_i + b_i;
         OpSub:   result_o = a_i - b_i;
         OpNot:   result_o = ~b_i;
         OpAnd:   result_o = a_i & b_i;
         OpOr:    result_o = a_i | b_i;
         OpMov:   result_o = b_i;
         default: result_o = a_i;
      endcase
   end

   assign product_o = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};

endmodule

// File: rtl/cpu_core_param.sv
// cpu_core_param: multi-cycle accumulator-style CPU core with external ROM/RAM.
//   clock       rising-edge clock
//   reset       asynchronous, active-high reset
//   mem         memory bus (master modport): rom_address/rom_data, ram_address,
//               ram_data_in, ram_data_out, ram_write
//   R0..R3      general registers
//   RHi, RLo    double-width multiply result
//   PC          program counter
//   IR          instruction register
//   state       current FSM state (debug display)
// Parameters: DATA_W >= 8 (word width), ADDR_W <= DATA_W (address width).
module cpu_core_param
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
) (
   input  logic                clock,
   input  logic                reset,
   cpu_core_param_if.master    mem,
   output logic [DATA_W-1:0]   R0,
   output logic [DATA_W-1:0]   R1,
   output logic [DATA_W-1:0]   R2,
   output logic [DATA_W-1:0]   R3,
   output logic [DATA_W-1:0]   RHi,
   output logic [DATA_W-1:0]   RLo,
   output logic [ADDR_W-1:0]   PC,
   output logic [7:0]          IR,
   output logic [4:0]          state
);

   logic [DATA_W-1:0]   regs_q [4];
   logic [DATA_W-1:0]   rhi_q;
   logic [DATA_W-1:0]   rlo_q;
   logic [ADDR_W-1:0]   pc_q;
   logic [ADDR_W-1:0]   opnd_q;
   logic [ADDR_W-1:0]   rom_addr_q;
   logic [ADDR_W-1:0]   ram_addr_q;
   logic [DATA_W-1:0]   ram_wdata_q;
   logic                ram_write_q;
   logic [7:0]          ir_q;
   logic                opw_wait_q;
   state_e              state_q;

   logic [3:0]          op;
   logic [1:0]          rd_idx;
   logic [1:0]          rs_idx;
   logic [DATA_W-1:0]   rd_val;
   logic [DATA_W-1:0]   rs_val;
   logic [DATA_W-1:0]   alu_result;
   logic [2*DATA_W-1:0] alu_product;
   logic [ADDR_W-1:0]   pc_inc;
   logic [ADDR_W-1:0]   rom_opnd_addr;
   logic [7:0]          fetch_ir;

   assign op            = ir_opcode(ir_q);
   assign rd_idx        = ir_rd(ir_q);
   assign rs_idx        = ir_rs(ir_q);
   assign rd_val        = regs_q[rd_idx];
   assign rs_val        = regs_q[rs_idx];
   assign pc_inc        = pc_q + ADDR_W'(1);
   assign rom_opnd_addr = mem.rom_data[ADDR_W-1:0];
   assign fetch_ir      = mem.rom_data[7:0];

   cpu_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op_i      (op),
      .a_i       (rd_val),
      .b_i       (rs_val),
      .result_o  (alu_result),
      .product_o (alu_product)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
         rhi_q       <= '0;
         rlo_q       <= '0;
         pc_q        <= '0;
         opnd_q      <= '0;
         rom_addr_q  <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_write_q <= 1'b0;
         ir_q        <= '0;
         opw_wait_q  <= 1'b0;
         state_q     <= StRst;
      end else begin
         unique case (state_q)
            StRst: state_q <= StF0;
            StF0: begin
               rom_addr_q <= pc_q;
               state_q    <= StF1;
            end
            StF1: state_q <= StF2;
            StF2: begin
               ir_q       <= fetch_ir;
               pc_q       <= pc_inc;
               rom_addr_q <= pc_inc;
               opw_wait_q <= 1'b1;
               state_q    <= has_operand(ir_opcode(fetch_ir)) ? StOpw : StEx;
            end
            StEx: begin
               case (op)
                  OpAdd, OpSub, OpNot, OpAnd, OpOr, OpMov: regs_q[rd_idx] <= alu_result;
                  OpMul: begin
                     rhi_q <= alu_product[2*DATA_W-1:DATA_W];
                     rlo_q <= alu_product[DATA_W-1:0];
                  end
                  default: ;
               endcase
               state_q <= StF0;
            end
            // Operand fetch waits two cycles, giving the 6-cycle operand
            // instruction timing of the original board CPU.
            StOpw: begin
               opw_wait_q <= 1'b0;
               if (!opw_wait_q) begin
                  state_q <= StOpl;
               end
            end
            StOpl: begin
               opnd_q <= rom_opnd_addr;
               pc_q   <= pc_inc;
               case (op)
                  OpLdi: begin
                     regs_q[rd_idx] <= mem.rom_data;
                     state_q        <= StF0;
                  end
                  OpJmp: begin
                     pc_q    <= rom_opnd_addr;
                     state_q <= StF0;
                  end
                  OpJnz: begin
                     if (rs_val != '0) begin
                        pc_q <= rom_opnd_addr;
                     end
                     state_q <= StF0;
                  end
                  OpSt:    state_q <= StStw;
                  OpLd:    state_q <= StLda;
                  default: state_q <= StF0;
               endcase
            end
            StStw: begin
               ram_addr_q  <= opnd_q;
               ram_wdata_q <= rs_val;
               ram_write_q <= 1'b1;
               state_q     <= StSte;
            end
            StSte: begin
               ram_write_q <= 1'b0;
               state_q     <= StF0;
            end
            StLda: begin
               ram_addr_q <= opnd_q;
               state_q    <= StLdw1;
            end
            StLdw1: state_q <= StLdw2;
            StLdw2: state_q <= StLdl;
            StLdl: begin
               regs_q[rd_idx] <= mem.ram_data_out;
               state_q        <= StF0;
            end
            default: state_q <= StRst;
         endcase
      end
   end

   assign mem.rom_address = rom_addr_q;
   assign mem.ram_address = ram_addr_q;
   assign mem.ram_data_in = ram_wdata_q;
   assign mem.ram_write   = ram_write_q;

   assign R0    = regs_q[0];
   assign R1    = regs_q[1];
   assign R2    = regs_q[2];
   assign R3    = regs_q[3];
   assign RHi   = rhi_q;
   assign RLo   = rlo_q;
   assign PC    = pc_q;
   assign IR    = ir_q;
   assign state = state_q;

endmodule

// File: tb/tb_cpu_core_param.sv
// Testbench for cpu_core_param: instruction-level reference model with
// per-cycle checks of the RAM write strobe, plus directed programs and a
// 16/10-bit width-scaling instance.
module tb_cpu_core_param;
   import cpu_pkg::*;

   localparam int unsigned DW   = 8;
   localparam int unsigned AW   = 8;
   localparam int unsigned DW2  = 16;
   localparam int unsigned AW2  = 10;
   localparam int          DMOD = 1 << DW;
   localparam int          AMOD = 1 << AW;

   logic clock  = 1'b0;
   logic reset  = 1'b1;
   logic reset2 = 1'b1;
   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;
   int edges   = 0;
   int n_writes = 0;
   always @(posedge clock) edges <= edges + 1;

   // ---------------- DUT 1: 8/8 ----------------
   cpu_core_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
   logic [DW-1:0] r0, r1, r2, r3, rhi, rlo;
   logic [AW-1:0] pc;
   logic [7:0]    ir;
   logic [4:0]    st;

   cpu_core_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clock (clock), .reset (reset), .mem (bus),
      .R0 (r0), .R1 (r1), .R2 (r2), .R3 (r3), .RHi (rhi), .RLo (rlo),
      .PC (pc), .IR (ir), .state (st)
   );

   logic [DW-1:0] rom [AMOD];
   logic [DW-1:0] ram [AMOD];
   bit            ram_ready = 1'b0;

   // Synchronous-read memories; RAM is seeded with a fixed pattern on the first edge.
   always @(posedge clock) begin
      if (!ram_ready) begin
         for (int i = 0; i < AMOD; i++) ram[i] = DW'(i * 37 + 11);
         ram_ready = 1'b1;
      end
      bus.rom_data     <= rom[bus.rom_address];
      bus.ram_data_out <= ram[bus.ram_address];
      if (bus.ram_write) begin
         ram[bus.ram_address] = bus.ram_data_in;
         n_writes = n_writes + 1;
      end
   end

   // ---------------- DUT 2: 16/10 ----------------
   cpu_core_param_if #(.DATA_W(DW2), .ADDR_W(AW2)) bus2 ();
   logic [DW2-1:0] r0_2, r1_2, r2_2, r3_2, rhi_2, rlo_2;
   logic [AW2-1:0] pc_2;
   logic [7:0]     ir_2;
   logic [4:0]     st_2;
   logic [DW2-1:0] rom2 [1 << AW2];

   cpu_core_param #(.DATA_W(DW2), .ADDR_W(AW2)) dut2 (
      .clock (clock), .reset (reset2), .mem (bus2),
      .R0 (r0_2), .R1 (r1_2), .R2 (r2_2), .R3 (r3_2), .RHi (rhi_2), .RLo (rlo_2),
      .PC (pc_2), .IR (ir_2), .state (st_2)
   );

   always @(posedge clock) begin
      bus2.rom_data     <= rom2[bus2.rom_address];
      bus2.ram_data_out <= '0;
   end

   // ---------------- reference model (instruction level) ----------------
   int m_r [4];
   int m_hi, m_lo, m_pc, m_ir;
   int m_ram [AMOD];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_r[i] = 0;
      m_hi = 0; m_lo = 0; m_pc = 0; m_ir = 0;
   endtask

   // Executes one instruction on the model; returns its length in cycles and
   // any RAM write it performs (applied by the caller once the write happens).
   task automatic step(output int len, output bit is_st, output int wa, output int wd);
      int ins, op, rd, rs, opw, nxt, prod;
      ins = int'(rom[m_pc]) % 256;
      op  = ins / 16;
      rd  = (ins / 4) % 4;
      rs  = ins % 4;
      opw = int'(rom[(m_pc + 1) % AMOD]);
      m_ir = ins;
      is_st = 1'b0; wa = 0; wd = 0;
      len = 4;
      nxt = (m_pc + 1) % AMOD;
      case (op)
         1: m_r[rd] = (m_r[rd] + m_r[rs]) % DMOD;
         2: m_r[rd] = (m_r[rd] - m_r[rs] + DMOD) % DMOD;
         3: m_r[rd] = DMOD - 1 - m_r[rs];
         4: m_r[rd] = m_r[rd] & m_r[rs];
         5: m_r[rd] = m_r[rd] | m_r[rs];
         6: m_r[rd] = m_r[rs];
         12: begin
            prod = m_r[rd] * m_r[rs];
            m_hi = prod / DMOD;
            m_lo = prod % DMOD;
         end
         default: ;
      endcase
      if (op >= 7 && op <= 11) begin
         len = 6;
         nxt = (m_pc + 2) % AMOD;
         case (op)
            7: begin len = 8; is_st = 1'b1; wa = opw % AMOD; wd = m_r[rs]; end
            8: m_r[rd] = opw;
            9: begin len = 10; m_r[rd] = m_ram[opw % AMOD]; end
            10: nxt = opw % AMOD;
            11: if (m_r[rs] != 0) nxt = opw % AMOD;
            default: ;
         endcase
      end
      m_pc = nxt;
   endtask

   task automatic check_arch();
      check("R0", r0, m_r[0]);
      check("R1", r1, m_r[1]);
      check("R2", r2, m_r[2]);
      check("R3", r3, m_r[3]);
      check("RHi", rhi, m_hi);
      check("RLo", rlo, m_lo);
      check("PC", pc, m_pc);
      check("IR", ir, m_ir);
      check("state_f0", st, 32'(StF0));
   endtask

   // Called at the negedge of an F0 cycle. abort_off >= 0 stops the last
   // instruction at that cycle offset without completing it.
   task automatic run(input int n, input int abort_off);
      int len, wa, wd;
      bit is_st;
      for (int k = 0; k < n; k++) begin
         check_arch();
         step(len, is_st, wa, wd);
         for (int c = 0; c < len; c++) begin
            check("ram_write", bus.ram_write, (is_st && c == 7) ? 32'd1 : 32'd0);
            if (is_st && c == 7) begin
               check("ram_address", bus.ram_address, wa);
               check("ram_data_in", bus.ram_data_in, wd);
            end
            if (k == n - 1 && c == abort_off) return;
            @(negedge clock);
         end
         if (is_st) m_ram[wa] = wd;
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_R0", r0, 0);
      check("rst_R1", r1, 0);
      check("rst_R2", r2, 0);
      check("rst_R3", r3, 0);
      check("rst_RHi", rhi, 0);
      check("rst_RLo", rlo, 0);
      check("rst_PC", pc, 0);
      check("rst_IR", ir, 0);
      check("rst_state", st, 32'(StRst));
      check("rst_rom_address", bus.rom_address, 0);
      check("rst_ram_address", bus.ram_address, 0);
      check("rst_ram_data_in", bus.ram_data_in, 0);
      check("rst_ram_write", bus.ram_write, 0);
   endtask

   // Asserts reset at a negedge, checks outputs, holds across an edge and
   // checks no RAM write slipped through.
   task automatic assert_reset();
      int w0;
      w0 = n_writes;
      reset = 1'b1;
      #1;
      check_reset_outputs();
      @(negedge clock);
      check("rst_no_write", n_writes, w0);
      check("rst_hold_write", bus.ram_write, 0);
      for (int i = 0; i < AMOD; i++) rom[i] = '0;
   endtask

   task automatic release_reset();
      reset = 1'b0;
      model_reset();
      @(negedge clock);
   endtask

   int e0, w0;

   initial begin
      for (int i = 0; i < AMOD; i++) begin
         rom[i]   = '0;
         m_ram[i] = (i * 37 + 11) % DMOD;
      end
      for (int i = 0; i < (1 << AW2); i++) rom2[i] = '0;
      model_reset();
      @(negedge clock);

      // ALU program: R0=8, R1=0xFB, 21 edges after release incl. the RST cycle
      assert_reset();
      rom[0] = 8'h80; rom[1] = 8'h05; rom[2] = 8'h84; rom[3] = 8'h03;
      rom[4] = 8'h11; rom[5] = 8'h24;
      e0 = edges;
      release_reset();
      run(4, -1);
      check_arch();
      check("alu_R0", r0, 32'h08);
      check("alu_R1", r1, 32'hFB);
      check("alu_edges", edges - e0, 21);

      // Store then load back through RAM
      assert_reset();
      rom[0] = 8'h88; rom[1] = 8'hAA; rom[2] = 8'h72; rom[3] = 8'h10;
      rom[4] = 8'h9C; rom[5] = 8'h10;
      e0 = edges; w0 = n_writes;
      release_reset();
      run(3, -1);
      check_arch();
      check("stld_R3", r3, 32'hAA);
      check("stld_writes", n_writes - w0, 1);
      check("stld_ram10", ram[8'h10], 32'hAA);
      check("stld_edges", edges - e0, 25);

      // Countdown loop with JNZ
      assert_reset();
      rom[0] = 8'h80; rom[1] = 8'h03; rom[2] = 8'h84; rom[3] = 8'h01;
      rom[4] = 8'h21; rom[5] = 8'hB0; rom[6] = 8'h04;
      release_reset();
      run(8, -1);
      check_arch();
      check("loop_R0", r0, 0);
      check("loop_PC", pc, 7);

      // 8x8 multiply
      assert_reset();
      rom[0] = 8'h80; rom[1] = 8'hFF; rom[2] = 8'h84; rom[3] = 8'hFF; rom[4] = 8'hC1;
      release_reset();
      run(3, -1);
      check_arch();
      check("mul_RHi", rhi, 32'hFE);
      check("mul_RLo", rlo, 32'h01);

      // JMP to top of memory, NOP there wraps PC
      assert_reset();
      rom[0] = 8'hA0; rom[1] = 8'hFF; rom[8'hFF] = 8'h00;
      release_reset();
      run(2, -1);
      check_arch();
      check("wrap_PC", pc, 0);

      // Reset while ram_write is high in STE
      assert_reset();
      rom[0] = 8'h88; rom[1] = 8'h55; rom[2] = 8'h72; rom[3] = 8'h20;
      release_reset();
      run(2, 7);
      w0 = n_writes;
      assert_reset();
      check("ste_abort_writes", n_writes, w0);
      check("ste_abort_ram", ram[8'h20], m_ram[8'h20]);
      rom[0] = 8'h88; rom[1] = 8'h55; rom[2] = 8'h72; rom[3] = 8'h20;
      release_reset();
      run(2, -1);
      check_arch();
      check("ste_restart_ram", ram[8'h20], 32'h55);

      // Reset during LDW1
      assert_reset();
      rom[0] = 8'h8C; rom[1] = 8'h77; rom[2] = 8'h94; rom[3] = 8'h30;
      release_reset();
      run(2, 7);
      check("ldw1_ram_address", bus.ram_address, 32'h30);
      assert_reset();
      rom[0] = 8'h8C; rom[1] = 8'h77; rom[2] = 8'h94; rom[3] = 8'h30;
      release_reset();
      run(2, -1);
      check_arch();

      // Random programs against the model
      for (int t = 0; t < 3; t++) begin
         assert_reset();
         for (int i = 0; i < AMOD; i++) rom[i] = DW'($urandom);
         release_reset();
         run(150, -1);
         check_arch();
      end

      // Width scaling: DATA_W=16, ADDR_W=10
      rom2[0] = 16'h0080; rom2[1] = 16'hFFFF; rom2[2] = 16'h0084; rom2[3] = 16'hFFFF;
      rom2[4] = 16'h00C1; rom2[5] = 16'h00A0; rom2[6] = 16'h03FF; rom2[10'h3FF] = 16'h5A00;
      reset2 = 1'b0;
      repeat (27) @(negedge clock);
      check("w16_R0", r0_2, 32'hFFFF);
      check("w16_R1", r1_2, 32'hFFFF);
      check("w16_R2", r2_2, 0);
      check("w16_R3", r3_2, 0);
      check("w16_RHi", rhi_2, 32'hFFFE);
      check("w16_RLo", rlo_2, 32'h0001);
      check("w16_PC", pc_2, 0);
      check("w16_IR", ir_2, 0);
      check("w16_state", st_2, 32'(StF0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
